// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: access type encoding and default capacity.
package dmem_pkg;

  typedef enum logic [1:0] {
    RwByte = 2'b00,
    RwHalf = 2'b01,
    RwWord = 2'b10
  } rw_type_e;

  localparam int unsigned DEFAULT_MEM_SIZE = 512;

  // Access size in bytes; the reserved encoding is treated as a word.
  function automatic logic [2:0] rw_size(logic [1:0] rw_type);
    case (rw_type)
      RwByte:  return 3'd1;
      RwHalf:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer advances past the granted port.
module rr_arb2 #(
  parameter bit PtrInit = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // ptr_q names the port that wins when both request
  logic ptr_q, ptr_d;

  // Grant selection and pointer advance; every grant is an accept.
  always_comb begin
    gnt_o = 2'b00;
    if (!rst_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    ptr_d = ptr_q;
    if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= PtrInit;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one combinational-read data memory with
// a one-deep response slot per requester.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter int unsigned RR_INIT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic        req_we_0,
  input  logic [1:0]  req_type_0,
  input  logic [31:0] req_addr_0,
  input  logic [31:0] req_wdata_0,
  input  logic        req_sign_ext_0,
  output logic        rsp_valid_0,
  input  logic        rsp_ready_0,
  output logic [31:0] rsp_rdata_0,
  output logic        rsp_err_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic        req_we_1,
  input  logic [1:0]  req_type_1,
  input  logic [31:0] req_addr_1,
  input  logic [31:0] req_wdata_1,
  input  logic        req_sign_ext_1,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_rdata_1,
  output logic        rsp_err_1,
  output logic        mem_write_en,
  output logic [1:0]  mem_type_control,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_sign_ext,
  input  logic [31:0] mem_dout
);

  logic [1:0]  rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q [2];
  logic [1:0]  rsp_ready, eligible, arb_req, gnt;
  logic        accept;

  logic        sel_we, sel_sign_ext, acc_err;
  logic [1:0]  sel_type;
  logic [31:0] sel_addr, sel_wdata;
  logic [32:0] last_byte;

  assign rsp_ready = {rsp_ready_1, rsp_ready_0};
  // A port may issue only if its slot is free or being drained this cycle
  assign eligible  = ~rsp_valid_q | rsp_ready;
  assign arb_req   = {req_valid_1, req_valid_0} & eligible;

  rr_arb2 #(
    .PtrInit (RR_INIT != 0)
  ) u_rr_arb2 (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (arb_req),
    .gnt_o (gnt)
  );

  assign req_ready_0 = gnt[0];
  assign req_ready_1 = gnt[1];
  assign accept      = |gnt;

  // Mux the granted request and classify it.
  always_comb begin
    sel_we       = gnt[1] ? req_we_1       : req_we_0;
    sel_type     = gnt[1] ? req_type_1     : req_type_0;
    sel_addr     = gnt[1] ? req_addr_1     : req_addr_0;
    sel_wdata    = gnt[1] ? req_wdata_1    : req_wdata_0;
    sel_sign_ext = gnt[1] ? req_sign_ext_1 : req_sign_ext_0;
    // 33-bit sum so an address near 2^32 cannot wrap into range
    last_byte    = {1'b0, sel_addr} + 33'(rw_size(sel_type)) - 33'd1;
    acc_err      = (sel_type == 2'b11) ||
                   ((sel_type == RwHalf) && sel_addr[0]) ||
                   ((sel_type == RwWord) && (sel_addr[1:0] != 2'b00)) ||
                   (last_byte >= 33'(MEM_SIZE));
  end

  // Memory-side drive: granted request on accept, quiet defaults otherwise.
  always_comb begin
    mem_write_en     = 1'b0;
    mem_type_control = RwWord;
    mem_addr         = '0;
    mem_din          = '0;
    mem_sign_ext     = 1'b0;
    if (accept) begin
      mem_write_en     = sel_we & ~acc_err;
      mem_type_control = sel_type;
      mem_addr         = sel_addr;
      mem_din          = sel_wdata;
      mem_sign_ext     = sel_sign_ext;
    end
  end

  // Response slots: fill on accept, hold until drained, refill wins over drain.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        rsp_valid_q[p] <= 1'b0;
        rsp_err_q[p]   <= 1'b0;
        rsp_rdata_q[p] <= '0;
      end else if (gnt[p]) begin
        rsp_valid_q[p] <= 1'b1;
        rsp_err_q[p]   <= acc_err;
        rsp_rdata_q[p] <= (acc_err || sel_we) ? 32'd0 : mem_dout;
      end else if (rsp_ready[p]) begin
        rsp_valid_q[p] <= 1'b0;
        rsp_err_q[p]   <= 1'b0;
        rsp_rdata_q[p] <= '0;
      end
    end
  end

  assign rsp_valid_0 = rsp_valid_q[0];
  assign rsp_valid_1 = rsp_valid_q[1];
  assign rsp_err_0   = rsp_err_q[0];
  assign rsp_err_1   = rsp_err_q[1];
  assign rsp_rdata_0 = rsp_rdata_q[0];
  assign rsp_rdata_1 = rsp_rdata_q[1];

endmodule
